uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the existing uart_tx, sharing its baud parameterisation.
- Synchronises the asynchronous rx line, detects and validates the start bit, mid-bit samples 8 data bits LSB first, then checks the stop bit.
- Presents each received byte with a one-cycle strobe.
- Feeds a command/console path, or loops back against uart_tx in benches.

Parameters:
- BAUD_COUNT, 2, clocks per bit period; same meaning and value as the matching uart_tx. Minimum 2.
- BAUD_COUNT_SIZE, 7, width of the internal baud down-counter; must hold BAUD_COUNT-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; idle high; asynchronous to clk.
- data  output  8  last correctly framed byte; holds its value until the next good frame.
- stb  output  1  one-cycle pulse; data is valid and newly updated in this cycle.
- frame_err  output  1  one-cycle pulse; stop bit sampled low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - data=8'h00, stb=0, frame_err=0, busy=0.
  - State IDLE, both synchroniser flops = 1, baud counter = 0, bit counter = 0, shift register = 0.
  - Reset mid-frame abandons the frame with no stb and no frame_err.
- Synchroniser: 2 flops; rx_s is the second flop. All decisions use rx_s, so line-to-decision latency is 2 clocks.
- HALF = BAUD_COUNT/2 (integer division, >=1).
- Baud counter counts down; the "sample" event is the cycle in which it equals 0.
- IDLE:
  - rx_s==0 -> START, load counter with HALF-1.
  - Otherwise stay in IDLE.
- START (sample event):
  - rx_s==1 -> glitch; return to IDLE with no output.
  - rx_s==0 -> DATA; load counter with BAUD_COUNT-1; bit counter = 0.
- DATA (sample event):
  - Shift rx_s in at bit 7 and shift right, so the first data bit ends at bit 0.
  - Increment bit counter and reload counter with BAUD_COUNT-1.
  - After the 8th sample -> STOP.
- STOP (sample event):
  - rx_s==1 -> data<=shift register, stb=1 for exactly this next cycle, -> IDLE.
  - rx_s==0 -> frame_err=1 for one cycle, data unchanged, -> BREAK.
- BREAK: wait for rx_s==1, then -> IDLE. A held-low line (break) yields exactly one frame_err, not repeated frames.
- Back-to-back frames:
  - IDLE is re-entered at mid-stop-bit, so a start edge arriving right after the stop bit is caught.
  - A start bit already low on the cycle IDLE is entered is accepted in that same cycle.
- stb and frame_err are never high together. busy falls in the same cycle stb/frame_err rises, except BREAK, where busy stays high until the line returns high.
- No receive buffer: the consumer must take data within one frame time. A new good frame overwrites data.

Test Plan:
- BAUD_COUNT=4, drive 8N1 frame 8'h48 ('H'), 4 clk/bit -> exactly one stb; data=8'h48 on the stb cycle; frame_err stays 0; busy returns low.
- Frames 8'h00 then 8'hFF back-to-back with no idle gap -> two stb pulses with data 8'h00 then 8'hFF; no frame_err.
- rx low pulse of 1 clk while idle (BAUD_COUNT=4) -> returns to IDLE; no stb or frame_err; data keeps its prior value.
- Frame 8'hA5 with stop bit low, then rx held low 40 clks, then high -> exactly one frame_err pulse; data unchanged; busy high until rx returns high; next frame 8'h3C received correctly.
- rst_n asserted mid data bit 4 of a frame, released, then frame 8'h55 -> no output from the aborted frame; 8'h55 received with one stb.
- Loopback: uart_tx (BAUD_COUNT=2) sends "HELLO!!!" -> 8 stb pulses with bytes 8'h48,45,4C,4C,4F,21,21,21 in order; no frame_err.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver. Two-flop synchronised rx line, start-bit
//                validation at mid-bit, LSB-first data capture at mid-bit,
//                stop-bit check. Good frames pulse stb with the byte on data;
//                a low stop bit pulses frame_err once and waits out any break.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
   parameter int BAUD_COUNT      = 2,   // clocks per bit period, >= 2
   parameter int BAUD_COUNT_SIZE = 7    // baud down-counter width, holds BAUD_COUNT-1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data,
   output logic       stb,
   output logic       frame_err,
   output logic       busy
);

   // Counter reload values: half a bit to reach mid start bit, a full bit after
   localparam logic [BAUD_COUNT_SIZE-1:0] c_HALF_LOAD = BAUD_COUNT_SIZE'((BAUD_COUNT / 2) - 1);
   localparam logic [BAUD_COUNT_SIZE-1:0] c_BIT_LOAD  = BAUD_COUNT_SIZE'(BAUD_COUNT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic                       r_rx_meta;
   logic                       r_rx_s;
   logic [BAUD_COUNT_SIZE-1:0] r_baud_cnt;
   logic [BAUD_COUNT_SIZE-1:0] w_baud_nxt;
   logic [2:0]                 r_bit_cnt;
   logic [2:0]                 w_bit_nxt;
   logic [7:0]                 r_shift;
   logic [7:0]                 w_shift_nxt;
   logic [7:0]                 r_data;
   logic [7:0]                 w_data_nxt;
   logic                       r_stb;
   logic                       w_stb_nxt;
   logic                       r_frame_err;
   logic                       w_ferr_nxt;
   logic                       w_sample;

   // Sample event: the baud counter has run down to zero
   assign w_sample  = (r_baud_cnt == '0);

   assign data      = r_data;
   assign stb       = r_stb;
   assign frame_err = r_frame_err;
   assign busy      = (r_state != S_IDLE);

   // Two-flop synchroniser for the asynchronous line; resets to idle-high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath registers follow the next-state logic's decisions
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_baud_cnt  <= '0;
         r_bit_cnt   <= 3'd0;
         r_shift     <= 8'h00;
         r_data      <= 8'h00;
         r_stb       <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_baud_cnt  <= w_baud_nxt;
         r_bit_cnt   <= w_bit_nxt;
         r_shift     <= w_shift_nxt;
         r_data      <= w_data_nxt;
         r_stb       <= w_stb_nxt;
         r_frame_err <= w_ferr_nxt;
      end
   end

   // Next-state and datapath decisions; strobes default low so they last one cycle
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud_cnt;
      w_bit_nxt   = r_bit_cnt;
      w_shift_nxt = r_shift;
      w_data_nxt  = r_data;
      w_stb_nxt   = 1'b0;
      w_ferr_nxt  = 1'b0;

      case (r_state)
         S_IDLE: begin
            // Checked every cycle, so a start bit already low on IDLE entry is taken at once
            if (!r_rx_s) begin
               w_state_nxt = S_START;
               w_baud_nxt  = c_HALF_LOAD;
            end
         end

         S_START: begin
            if (w_sample) begin
               if (r_rx_s) begin
                  // Line went back high before mid start bit: treat as a glitch
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_DATA;
                  w_baud_nxt  = c_BIT_LOAD;
                  w_bit_nxt   = 3'd0;
               end
            end else begin
               w_baud_nxt = r_baud_cnt - 1'b1;
            end
         end

         S_DATA: begin
            if (w_sample) begin
               // LSB arrives first, so shift right and insert at the top
               w_shift_nxt = {r_rx_s, r_shift[7:1]};
               w_baud_nxt  = c_BIT_LOAD;
               w_bit_nxt   = r_bit_cnt + 1'b1;
               if (r_bit_cnt == 3'd7) begin
                  w_state_nxt = S_STOP;
               end
            end else begin
               w_baud_nxt = r_baud_cnt - 1'b1;
            end
         end

         S_STOP: begin
            if (w_sample) begin
               // Leave at mid stop bit so an immediately following start edge is caught
               if (r_rx_s) begin
                  w_data_nxt  = r_shift;
                  w_stb_nxt   = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_ferr_nxt  = 1'b1;
                  w_state_nxt = S_BREAK;
               end
            end else begin
               w_baud_nxt = r_baud_cnt - 1'b1;
            end
         end

         S_BREAK: begin
            // Hold off until the line is released so a break reports only once
            if (r_rx_s) begin
               w_state_nxt = S_IDLE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed self-checking bench for uart_rx. One instance at
//                4 clocks/bit for framing cases, one at 2 clocks/bit for a
//                "HELLO!!!" loopback-style byte stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic       rx2;
   logic [7:0] data1;
   logic       stb1;
   logic       ferr1;
   logic       busy1;
   logic [7:0] data2;
   logic       stb2;
   logic       ferr2;
   logic       busy2;

   int         n_assert;
   int         n_fail;
   int         ferr1_cnt;
   int         ferr2_cnt;
   int         both1_cnt;
   int         both2_cnt;
   logic [7:0] q1[$];
   logic [7:0] q2[$];
   logic [7:0] hello [8];

   uart_rx #(.BAUD_COUNT(4), .BAUD_COUNT_SIZE(7)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .data      (data1),
      .stb       (stb1),
      .frame_err (ferr1),
      .busy      (busy1)
   );

   uart_rx #(.BAUD_COUNT(2), .BAUD_COUNT_SIZE(7)) u_dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx2),
      .data      (data2),
      .stb       (stb2),
      .frame_err (ferr2),
      .busy      (busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every strobe and error pulse on the falling edge
   always @(negedge clk) begin
      if (stb1) q1.push_back(data1);
      if (stb2) q2.push_back(data2);
      if (ferr1) ferr1_cnt++;
      if (ferr2) ferr2_cnt++;
      if (stb1 && ferr1) both1_cnt++;
      if (stb2 && ferr2) both2_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Hold a line level for n clock edges; returns just after an edge
   task automatic drive(input bit sel, input logic v, input int n);
      if (sel) rx2 = v;
      else     rx  = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop_v, input int bp);
      drive(sel, 1'b0, bp);
      for (int i = 0; i < 8; i++) drive(sel, b[i], bp);
      drive(sel, stop_v, bp);
   endtask

   initial begin
      n_assert  = 0;
      n_fail    = 0;
      ferr1_cnt = 0;
      ferr2_cnt = 0;
      both1_cnt = 0;
      both2_cnt = 0;
      hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h21, 8'h21, 8'h21};
      rx    = 1'b1;
      rx2   = 1'b1;
      rst_n = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_data",  {24'h0, data1}, 32'h00);
      chk("reset_stb",   {31'h0, stb1},  32'h0);
      chk("reset_ferr",  {31'h0, ferr1}, 32'h0);
      chk("reset_busy",  {31'h0, busy1}, 32'h0);
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 4);

      // Single frame 'H'
      send_frame(1'b0, 8'h48, 1'b1, 4);
      drive(1'b0, 1'b1, 10);
      chk("h_stb_count", q1.size(), 1);
      chk("h_byte",      {24'h0, q1[0]}, 32'h48);
      chk("h_data_hold", {24'h0, data1}, 32'h48);
      chk("h_ferr",      ferr1_cnt, 0);
      chk("h_busy_low",  {31'h0, busy1}, 32'h0);

      // Back-to-back 00 then FF with no idle gap
      send_frame(1'b0, 8'h00, 1'b1, 4);
      send_frame(1'b0, 8'hFF, 1'b1, 4);
      drive(1'b0, 1'b1, 10);
      chk("b2b_stb_count", q1.size(), 3);
      chk("b2b_byte0",     {24'h0, q1[1]}, 32'h00);
      chk("b2b_byte1",     {24'h0, q1[2]}, 32'hFF);
      chk("b2b_ferr",      ferr1_cnt, 0);

      // One-clock glitch while idle
      drive(1'b0, 1'b0, 1);
      drive(1'b0, 1'b1, 12);
      chk("glitch_stb_count", q1.size(), 3);
      chk("glitch_ferr",      ferr1_cnt, 0);
      chk("glitch_data",      {24'h0, data1}, 32'hFF);
      chk("glitch_busy",      {31'h0, busy1}, 32'h0);

      // Bad stop bit followed by a 40-clock break
      send_frame(1'b0, 8'hA5, 1'b0, 4);
      drive(1'b0, 1'b0, 20);
      chk("brk_busy_high", {31'h0, busy1}, 32'h1);
      chk("brk_ferr_once", ferr1_cnt, 1);
      drive(1'b0, 1'b0, 20);
      chk("brk_busy_still", {31'h0, busy1}, 32'h1);
      drive(1'b0, 1'b1, 8);
      chk("brk_busy_low",   {31'h0, busy1}, 32'h0);
      chk("brk_ferr_total", ferr1_cnt, 1);
      chk("brk_no_stb",     q1.size(), 3);
      chk("brk_data_kept",  {24'h0, data1}, 32'hFF);
      send_frame(1'b0, 8'h3C, 1'b1, 4);
      drive(1'b0, 1'b1, 10);
      chk("after_brk_count", q1.size(), 4);
      chk("after_brk_byte",  {24'h0, q1[3]}, 32'h3C);

      // Reset part-way through data bit 4
      drive(1'b0, 1'b0, 4);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 4);
      drive(1'b0, 1'b0, 2);
      rst_n = 1'b0;
      rx    = 1'b1;
      #1;
      chk("rst_mid_data", {24'h0, data1}, 32'h00);
      chk("rst_mid_busy", {31'h0, busy1}, 32'h0);
      drive(1'b0, 1'b1, 3);
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 30);
      chk("rst_abort_no_stb",  q1.size(), 4);
      chk("rst_abort_no_ferr", ferr1_cnt, 1);
      send_frame(1'b0, 8'h55, 1'b1, 4);
      drive(1'b0, 1'b1, 10);
      chk("rst_55_count", q1.size(), 5);
      chk("rst_55_byte",  {24'h0, q1[4]}, 32'h55);

      // "HELLO!!!" back-to-back at 2 clocks/bit
      drive(1'b1, 1'b1, 4);
      for (int k = 0; k < 8; k++) send_frame(1'b1, hello[k], 1'b1, 2);
      drive(1'b1, 1'b1, 10);
      chk("hello_count", q2.size(), 8);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("hello_byte%0d", k), {24'h0, q2[k]}, {24'h0, hello[k]});
      end
      chk("hello_ferr", ferr2_cnt, 0);
      chk("hello_busy", {31'h0, busy2}, 32'h0);

      // Strobe and error never coincide
      chk("excl_dut1", both1_cnt, 0);
      chk("excl_dut2", both2_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
